// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: host command/result handshake and calculator step-protocol bundle
// Host side : cmd_valid/cmd_ready/cmd_ms/cmd_a/cmd_b in, res_valid/res_ready/res_data/res_ms out
// Calc side : calc_next/calc_ms/calc_din/calc_clear out, calc_done/calc_alu in
// Status    : busy (sequencer not idle), timeout_err (sticky watchdog abort flag)
// slave = sequencer view, master = host/calculator environment view
interface calc_sequencer_if #(parameter int DW = 16);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_ms;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic          calc_next;
  logic [2:0]    calc_ms;
  logic [DW-1:0] calc_din;
  logic          calc_clear;
  logic          calc_done;
  logic [DW-1:0] calc_alu;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [2:0]    res_ms;
  logic          busy;
  logic          timeout_err;
  modport slave (
    input  cmd_valid, cmd_ms, cmd_a, cmd_b, calc_done, calc_alu, res_ready,
    output cmd_ready, calc_next, calc_ms, calc_din, calc_clear, res_valid, res_data, res_ms,
           busy, timeout_err
  );
  modport master (
    output cmd_valid, cmd_ms, cmd_a, cmd_b, calc_done, calc_alu, res_ready,
    input  cmd_ready, calc_next, calc_ms, calc_din, calc_clear, res_valid, res_data, res_ms,
           busy, timeout_err
  );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: queues host ops and steps the calculator through next/MS/Din, returning ALU results
// Ports: clk, clear (sync active-high reset), bus (calc_sequencer_if.slave: command queue input,
//        calculator step protocol, one-entry result register, busy/timeout_err status)
// Parameters: DW operand width, DEPTH queue entries (power of 2, >=2), TIMEOUT watchdog cycles
// Define CALC_SEQ_TIMEOUT_EN to build the WAIT_DONE watchdog, ABORT state and timeout_err flag
module calc_sequencer #(
  parameter int DW = 16,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic clear,
  calc_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [2:0]    ms;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cmd_t;
  typedef enum logic [3:0] {
    IDLE, LOAD_A, GAP_A, LOAD_B, GAP_B, EXEC, WAIT_DONE, CAPTURE
`ifdef CALC_SEQ_TIMEOUT_EN
    , ABORT
`endif
  } state_t;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("calc_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT within 1..65535");
  end
  cmd_t          mem_q [DEPTH];
  cmd_t          cmd_in;
  cmd_t          work_q, work_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [2:0]    res_ms_q, res_ms_d;
  logic          full, push, pop, capture;
  assign cmd_in  = {bus.cmd_ms, bus.cmd_a, bus.cmd_b};
  assign full    = count_q == CW'(DEPTH);
  assign push    = bus.cmd_valid && !full;
  // Start only when the result slot is free or being emptied this cycle, so a capture never overwrites
  assign pop     = state_q == IDLE && count_q != '0 && (!res_valid_q || bus.res_ready);
  assign capture = state_q == WAIT_DONE && bus.calc_done;
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    work_d      = pop ? mem_q[rd_ptr_q] : work_q;
    res_valid_d = capture || (res_valid_q && !bus.res_ready);
    res_data_d  = capture ? bus.calc_alu : res_data_q;
    res_ms_d    = capture ? work_q.ms : res_ms_q;
  end
`ifdef CALC_SEQ_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        timed_out;
  // The counter sits at zero outside WAIT_DONE, so it is fresh on every entry from EXEC
  assign timed_out = cnt_q == 16'(TIMEOUT - 1);
  always_comb begin
    cnt_d         = state_q == WAIT_DONE ? cnt_q + 16'd1 : '0;
    timeout_err_d = timeout_err_q || state_q == ABORT;
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign bus.timeout_err = timeout_err_q;
  assign bus.calc_clear  = clear || state_q == ABORT;
`else
  assign bus.timeout_err = 1'b0;
  assign bus.calc_clear  = clear;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = pop ? LOAD_A : IDLE;
      LOAD_A:    state_d = GAP_A;
      GAP_A:     state_d = LOAD_B;
      LOAD_B:    state_d = GAP_B;
      GAP_B:     state_d = EXEC;
      EXEC:      state_d = WAIT_DONE;
`ifdef CALC_SEQ_TIMEOUT_EN
      WAIT_DONE: state_d = bus.calc_done ? CAPTURE : timed_out ? ABORT : WAIT_DONE;
`else
      WAIT_DONE: state_d = bus.calc_done ? CAPTURE : WAIT_DONE;
`endif
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      work_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ms_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      work_q      <= work_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ms_q    <= res_ms_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end
  // CAPTURE pulses next once more to walk the calculator back to its initial state
  assign bus.calc_next = state_q inside {LOAD_A, LOAD_B, EXEC, CAPTURE};
  assign bus.calc_ms   = state_q == IDLE ? 3'd0 : work_q.ms;
  assign bus.calc_din  = state_q == IDLE ? '0 : state_q inside {LOAD_A, GAP_A} ? work_q.a : work_q.b;
  assign bus.cmd_ready = !full;
  assign bus.busy      = state_q != IDLE;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ms    = res_ms_q;
endmodule
